ram_port_arbiter: RTL and testbench

- Shares the single RAM port (14-bit words, 6-bit address) between two requesters: A = control unit fetch/LDR/STR path, B = program loader / debug port.
- Sits between the requesters and the RAM. Only this block drives readRAM, writeRAM, address and write data.
- Round-robin arbitration, req/gnt/done handshake, one access in flight at a time.
- RAM read latency is set by a parameter.

---
 rtl/ram_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between requester A (control unit
// fetch/LDR/STR) and requester B (program loader / debug port).
// Round-robin arbitration with a req/gnt/done handshake and one access in
// flight at a time. Every output is registered. The RAM strobe is held for
// RD_LAT cycles, and RAMdata is sampled on the edge that ends the access.
// Optional feature: define RAM_ARB_LOCK_EN to add lock_a/lock_b. These let
// the requester granted last keep the port for burst transfers.

module ram_port_arbiter #(
  parameter int RD_LAT = 1,
  parameter int AW     = 6,
  parameter int DW     = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
`ifdef RAM_ARB_LOCK_EN
  input  logic          lock_a,
  input  logic          lock_b,
`endif
  output logic          gnt_a,
  output logic          done_a,
  output logic [DW-1:0] rdata_a,
  output logic          gnt_b,
  output logic          done_b,
  output logic [DW-1:0] rdata_b,
  output logic          readRAM,
  output logic          writeRAM,
  output logic [AW-1:0] address,
  output logic [DW-1:0] ramWdata,
  input  logic [DW-1:0] RAMdata
);

  // RD_LAT is at most 7, so a 3-bit down-counter covers the whole range.
  localparam int CW = 3;
  localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_b, last_b_nxt;   // 1 = B was granted last
  logic          cur_b, cur_b_nxt;     // requester owning the access in flight
  logic          cur_we, cur_we_nxt;   // access in flight is a write

  logic          gnt_a_nxt, gnt_b_nxt, done_a_nxt, done_b_nxt;
  logic [DW-1:0] rdata_a_nxt, rdata_b_nxt;
  logic          read_nxt, write_nxt;
  logic [AW-1:0] address_nxt;
  logic [DW-1:0] wdata_nxt;

  logic          sel_valid, sel_b;

  // Pick the winner. Round-robin favours whoever was not granted last; a held lock overrides it.
  always_comb begin
    sel_valid = req_a | req_b;
    if (req_a && req_b) begin
      sel_b = !last_b;
    end else begin
      sel_b = req_b;
    end
`ifdef RAM_ARB_LOCK_EN
    if (last_b && lock_b && req_b) begin
      sel_b = 1'b1;
    end else if (!last_b && lock_a && req_a) begin
      sel_b = 1'b0;
    end
`endif
  end

  // Next-state and next-output logic; the registered outputs hold unless a state says otherwise.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_b_nxt  = last_b;
    cur_b_nxt   = cur_b;
    cur_we_nxt  = cur_we;
    gnt_a_nxt   = 1'b0;
    gnt_b_nxt   = 1'b0;
    done_a_nxt  = 1'b0;
    done_b_nxt  = 1'b0;
    rdata_a_nxt = rdata_a;
    rdata_b_nxt = rdata_b;
    read_nxt    = readRAM;
    write_nxt   = writeRAM;
    address_nxt = address;
    wdata_nxt   = ramWdata;

    case (state)
      IDLE: begin
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
        if (sel_valid) begin
          cur_b_nxt  = sel_b;
          last_b_nxt = sel_b;
          cnt_nxt    = LAT_LOAD;
          state_nxt  = ACCESS;
          if (sel_b) begin
            address_nxt = addr_b;
            wdata_nxt   = wdata_b;
            cur_we_nxt  = we_b;
            read_nxt    = !we_b;
            write_nxt   = we_b;
            gnt_b_nxt   = 1'b1;
          end else begin
            address_nxt = addr_a;
            wdata_nxt   = wdata_a;
            cur_we_nxt  = we_a;
            read_nxt    = !we_a;
            write_nxt   = we_a;
            gnt_a_nxt   = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (cnt == CW'(1)) begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          state_nxt = DONE;
          if (cur_b) begin
            done_b_nxt = 1'b1;
            if (!cur_we) begin
              rdata_b_nxt = RAMdata;
            end
          end else begin
            done_a_nxt = 1'b1;
            if (!cur_we) begin
              rdata_a_nxt = RAMdata;
            end
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      DONE: begin
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and all outputs register here; reset drops any access in flight without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_b   <= 1'b1;
      cur_b    <= 1'b0;
      cur_we   <= 1'b0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      readRAM  <= 1'b0;
      writeRAM <= 1'b0;
      address  <= '0;
      ramWdata <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_b   <= last_b_nxt;
      cur_b    <= cur_b_nxt;
      cur_we   <= cur_we_nxt;
      gnt_a    <= gnt_a_nxt;
      gnt_b    <= gnt_b_nxt;
      done_a   <= done_a_nxt;
      done_b   <= done_b_nxt;
      rdata_a  <= rdata_a_nxt;
      rdata_b  <= rdata_b_nxt;
      readRAM  <= read_nxt;
      writeRAM <= write_nxt;
      address  <= address_nxt;
      ramWdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter. It drives two
// instances, one with RD_LAT=1 and one with RD_LAT=3, from the same stimulus.
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge after the rising edge under test. With RAM_ARB_LOCK_EN defined, the
// burst lock is exercised as well.

module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, we_a, req_b, we_b;
  logic [5:0]  addr_a, addr_b;
  logic [13:0] wdata_a, wdata_b, ramdata;
`ifdef RAM_ARB_LOCK_EN
  logic        lock_a, lock_b;
`endif

  logic        gnt_a1, done_a1, gnt_b1, done_b1, read1, write1;
  logic [13:0] rd_a1, rd_b1, wd1;
  logic [5:0]  address1;
  logic        gnt_a3, done_a3, gnt_b3, done_b3, read3, write3;
  logic [13:0] rd_a3, rd_b3, wd3;
  logic [5:0]  address3;

  int compared = 0;
  int mismatched = 0;

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  ram_port_arbiter #(.RD_LAT(1), .AW(6), .DW(14)) dut1 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
`ifdef RAM_ARB_LOCK_EN
    .lock_a(lock_a), .lock_b(lock_b),
`endif
    .gnt_a(gnt_a1), .done_a(done_a1), .rdata_a(rd_a1),
    .gnt_b(gnt_b1), .done_b(done_b1), .rdata_b(rd_b1),
    .readRAM(read1), .writeRAM(write1), .address(address1),
    .ramWdata(wd1), .RAMdata(ramdata)
  );

  ram_port_arbiter #(.RD_LAT(3), .AW(6), .DW(14)) dut3 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
`ifdef RAM_ARB_LOCK_EN
    .lock_a(lock_a), .lock_b(lock_b),
`endif
    .gnt_a(gnt_a3), .done_a(done_a3), .rdata_a(rd_a3),
    .gnt_b(gnt_b3), .done_b(done_b3), .rdata_b(rd_b3),
    .readRAM(read3), .writeRAM(write3), .address(address3),
    .ramWdata(wd3), .RAMdata(ramdata)
  );

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0; ramdata = '0;
`ifdef RAM_ARB_LOCK_EN
    lock_a = 1'b0; lock_b = 1'b0;
`endif
    #1 rst = 1'b0;
    #1;
    if ({gnt_a1, done_a1, gnt_b1, done_b1, read1, write1, rd_a1, rd_b1, wd1, address1} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_dut1: outputs=%h required 0",
               {gnt_a1, done_a1, gnt_b1, done_b1, read1, write1, rd_a1, rd_b1, wd1, address1});
    end
    compared++;
    if ({gnt_a3, done_a3, gnt_b3, done_b3, read3, write3, rd_a3, rd_b3, wd3, address3} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_dut3: outputs=%h required 0",
               {gnt_a3, done_a3, gnt_b3, done_b3, read3, write3, rd_a3, rd_b3, wd3, address3});
    end
    compared++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_read_a;
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h05; ramdata = 14'h1A3F;
    @(negedge clk);
    req_a = 1'b0;
    if ({gnt_a1, read1, write1, gnt_b1} !== 4'b1100) begin
      mismatched++;
      $display("[TB] FAIL read_a_edge0: gnt_a,read,write,gnt_b=%b required 1100", {gnt_a1, read1, write1, gnt_b1});
    end
    compared++;
    if (address1 !== 6'h05) begin
      mismatched++;
      $display("[TB] FAIL read_a_addr: address=%h required 05", address1);
    end
    compared++;
    @(negedge clk);
    if ({done_a1, gnt_a1, read1, done_b1} !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL read_a_edge1: done_a,gnt_a,read,done_b=%b required 1000", {done_a1, gnt_a1, read1, done_b1});
    end
    compared++;
    if (rd_a1 !== 14'h1A3F) begin
      mismatched++;
      $display("[TB] FAIL read_a_data: rdata_a=%h required 1a3f", rd_a1);
    end
    compared++;
    @(negedge clk);
    if ({done_a1, done_b1, gnt_b1} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL read_a_edge2: done_a,done_b,gnt_b=%b required 000", {done_a1, done_b1, gnt_b1});
    end
    compared++;
  endtask

  task automatic test_write_b;
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'h3F; wdata_b = 14'h3FFF; ramdata = 14'h2222;
    @(negedge clk);
    req_b = 1'b0;
    if ({gnt_b1, write1, read1, gnt_a1} !== 4'b1100) begin
      mismatched++;
      $display("[TB] FAIL write_b_edge0: gnt_b,write,read,gnt_a=%b required 1100", {gnt_b1, write1, read1, gnt_a1});
    end
    compared++;
    if ({address1, wd1} !== {6'h3F, 14'h3FFF}) begin
      mismatched++;
      $display("[TB] FAIL write_b_bus: address=%h wdata=%h required 3f 3fff", address1, wd1);
    end
    compared++;
    @(negedge clk);
    if ({done_b1, write1, read1, done_a1} !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL write_b_edge1: done_b,write,read,done_a=%b required 1000", {done_b1, write1, read1, done_a1});
    end
    compared++;
    if (rd_b1 !== 14'h0000) begin
      mismatched++;
      $display("[TB] FAIL write_b_rdata: rdata_b=%h required 0000", rd_b1);
    end
    compared++;
    @(negedge clk);
    if ({done_b1, read1} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL write_b_edge2: done_b,read=%b required 00", {done_b1, read1});
    end
    compared++;
  endtask

  task automatic test_round_robin;
    apply_reset();
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h01;
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'h02; wdata_b = 14'h0ABC;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (gnt_a1 !== ((k % 6) == 0)) begin
        mismatched++;
        $display("[TB] FAIL rr_gnt_a cycle %0d: gnt_a=%b required %b", k, gnt_a1, (k % 6) == 0);
      end
      compared++;
      if (gnt_b1 !== ((k % 6) == 3)) begin
        mismatched++;
        $display("[TB] FAIL rr_gnt_b cycle %0d: gnt_b=%b required %b", k, gnt_b1, (k % 6) == 3);
      end
      compared++;
      if ((read1 & write1) !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL rr_strobes cycle %0d: read=%b write=%b required not both", k, read1, write1);
      end
      compared++;
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rd_lat3;
    apply_reset();
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h10; ramdata = 14'h0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_a = 1'b0;
        if ({gnt_a3, address3} !== {1'b1, 6'h10}) begin
          mismatched++;
          $display("[TB] FAIL lat3_grant: gnt_a=%b address=%h required 1 10", gnt_a3, address3);
        end
        compared++;
      end
      if (read3 !== (k < 3)) begin
        mismatched++;
        $display("[TB] FAIL lat3_read cycle %0d: readRAM=%b required %b", k, read3, k < 3);
      end
      compared++;
      if (done_a3 !== (k == 3)) begin
        mismatched++;
        $display("[TB] FAIL lat3_done cycle %0d: done_a=%b required %b", k, done_a3, k == 3);
      end
      compared++;
      if (k == 3) begin
        if (rd_a3 !== 14'h0103) begin
          mismatched++;
          $display("[TB] FAIL lat3_data: rdata_a=%h required 0103", rd_a3);
        end
        compared++;
      end
      ramdata = 14'h0100 + 14'(k + 1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    apply_reset();
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h10;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'h22;
    #1;
    if ({gnt_a3, done_a3, gnt_b3, done_b3, read3, write3, rd_a3, rd_b3, wd3, address3} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midrst_outputs: outputs=%h required 0",
               {gnt_a3, done_a3, gnt_b3, done_b3, read3, write3, rd_a3, rd_b3, wd3, address3});
    end
    compared++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if ({done_a3, done_b3, read3} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL midrst_hold cycle %0d: done_a,done_b,read=%b required 000", k, {done_a3, done_b3, read3});
      end
      compared++;
    end
    rst = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    if ({gnt_b3, gnt_a3, read3, address3} !== {3'b101, 6'h22}) begin
      mismatched++;
      $display("[TB] FAIL midrst_regrant: gnt_b=%b gnt_a=%b read=%b address=%h required 1 0 1 22",
               gnt_b3, gnt_a3, read3, address3);
    end
    compared++;
    repeat (6) @(negedge clk);
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock;
    apply_reset();
    lock_b = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h07;
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'h08; wdata_b = 14'h0055;
    for (int g = 0; g < 7; g++) begin
      @(negedge clk);
      if (gnt_b1 !== (g < 4 || g == 5)) begin
        mismatched++;
        $display("[TB] FAIL lock_gnt_b grant %0d: gnt_b=%b required %b", g, gnt_b1, g < 4 || g == 5);
      end
      compared++;
      if (gnt_a1 !== (g == 4 || g == 6)) begin
        mismatched++;
        $display("[TB] FAIL lock_gnt_a grant %0d: gnt_a=%b required %b", g, gnt_a1, g == 4 || g == 6);
      end
      compared++;
      if (g == 3) begin
        lock_b = 1'b0;
      end
      repeat (2) @(negedge clk);
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask
`endif

  // Run every scenario in order and report the totals
  initial begin
    test_reset();
    test_read_a();
    test_write_b();
    test_round_robin();
    test_rd_lat3();
    test_reset_mid_access();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
